// File: rtl/reg_decoder.sv
// reg_decoder: registered one-hot decoder with a self-timed sweep mode.
// IDLE decodes sel (when enable) into d; clear_req starts a sweep that walks
// a single set bit across every output, then pulses clear_done for one cycle.
// Optional feature: define REG_DECODER_ZERO_MASK_EN to force d[ZERO_IDX] to 0.
module reg_decoder #(
  parameter  int SEL_W    = 5,
  parameter  int ZERO_IDX = 31,
  localparam int OUT_W    = 2**SEL_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SEL_W-1:0] sel,
  input  logic             enable,
  input  logic             clear_req,
  output logic [OUT_W-1:0] d,
  output logic             busy,
  output logic             clear_done
);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

`ifdef REG_DECODER_ZERO_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif

  // Out-of-range ZERO_IDX masks nothing rather than aliasing onto a real bit.
  localparam logic [OUT_W-1:0] ZMASK =
    (MASK_EN && ZERO_IDX >= 0 && ZERO_IDX < OUT_W) ? (OUT_W'(1) << ZERO_IDX) : '0;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   d_q, d_d;
  logic               clear_done_q, clear_done_d;
  logic               dec_vld;
  logic [SEL_W-1:0]   dec_idx;

  // Next-state, sweep counter and the index to decode on the coming edge.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    clear_done_d = 1'b0;
    dec_vld      = 1'b0;
    dec_idx      = '0;
    unique case (state_q)
      IDLE: begin
        if (clear_req) begin
          // Sweep start wins over a same-cycle decode request.
          state_d = SWEEP;
          cnt_d   = '0;
          dec_vld = 1'b1;
        end else if (enable) begin
          dec_vld = 1'b1;
          dec_idx = sel;
        end
      end
      SWEEP: begin
        if (cnt_q == {SEL_W{1'b1}}) begin
          // Terminal count: clear outputs and let the counter fall back to 0.
          state_d      = DONE;
          cnt_d        = '0;
          clear_done_d = 1'b1;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          dec_vld = 1'b1;
          dec_idx = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // One-hot expansion of the chosen index, with the optional hardwired-zero bit.
  always_comb begin
    d_d = ({{(OUT_W-1){1'b0}}, dec_vld} << dec_idx) & ~ZMASK;
  end

  // State, counter and output registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      d_q          <= '0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      d_q          <= d_d;
      clear_done_q <= clear_done_d;
    end
  end

  assign d          = d_q;
  assign clear_done = clear_done_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_reg_decoder.sv
// tb_reg_decoder: directed vectors against two instances (SEL_W=5 and SEL_W=3).
module tb_reg_decoder;

`ifdef REG_DECODER_ZERO_MASK_EN
  localparam bit MASK = 1'b1;
`else
  localparam bit MASK = 1'b0;
`endif

  logic        clk, reset;
  logic [4:0]  sel5;
  logic        en5, clr5, busy5, cd5;
  logic [31:0] d5;
  logic [2:0]  sel3;
  logic        en3, clr3, busy3, cd3;
  logic [7:0]  d3;

  int n_chk  = 0;
  int n_fail = 0;

  reg_decoder #(.SEL_W(5), .ZERO_IDX(31)) u5 (
    .clk(clk), .reset(reset), .sel(sel5), .enable(en5), .clear_req(clr5),
    .d(d5), .busy(busy5), .clear_done(cd5));

  // ZERO_IDX=31 is out of range for 8 outputs, so nothing is masked here.
  reg_decoder #(.SEL_W(3), .ZERO_IDX(31)) u3 (
    .clk(clk), .reset(reset), .sel(sel3), .enable(en3), .clear_req(clr3),
    .d(d3), .busy(busy3), .clear_done(cd3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] exp5(input int idx);
    logic [63:0] v;
    v = 64'd1 << idx;
    if (MASK && idx == 31) v = '0;
    return v;
  endfunction

  initial begin
    reset = 1'b1;
    sel5 = '0; en5 = 1'b0; clr5 = 1'b0;
    sel3 = '0; en3 = 1'b0; clr3 = 1'b0;

    // Reset state before any clock edge.
    #3;
    chk("rst_d5", d5, 0);
    chk("rst_busy5", busy5, 0);
    chk("rst_cd5", cd5, 0);
    chk("rst_d3", d3, 0);
    tick();
    reset = 1'b0;

    // Decode every select value on the wide instance.
    for (int s = 0; s < 32; s++) begin
      en5 = 1'b1; sel5 = 5'(s);
      tick();
      chk($sformatf("dec5_%0d", s), d5, exp5(s));
    end
    en5 = 1'b0;
    tick();
    chk("dec5_disable", d5, 0);

    // Sweep on the narrow instance with mid-sweep enable/clear pulses.
    clr3 = 1'b1;
    tick();
    clr3 = 1'b0;
    chk("sw3_first", d3, 8'h01);
    chk("sw3_busy0", busy3, 1);
    for (int i = 1; i < 8; i++) begin
      if (i == 3) begin en3 = 1'b1; sel3 = 3'd5; clr3 = 1'b1; end
      tick();
      en3 = 1'b0; clr3 = 1'b0;
      chk($sformatf("sw3_d%0d", i), d3, 64'd1 << i);
      chk($sformatf("sw3_busy%0d", i), busy3, 1);
      chk($sformatf("sw3_cd%0d", i), cd3, 0);
    end
    tick();
    chk("sw3_done_d", d3, 0);
    chk("sw3_done_cd", cd3, 1);
    chk("sw3_done_busy", busy3, 1);
    tick();
    chk("sw3_idle_cd", cd3, 0);
    chk("sw3_idle_busy", busy3, 0);
    chk("sw3_idle_d", d3, 0);

    // Same-cycle enable and clear_req: sweep start wins.
    en3 = 1'b1; sel3 = 3'd5; clr3 = 1'b1;
    tick();
    en3 = 1'b0; clr3 = 1'b0;
    chk("prio_d", d3, 8'h01);
    for (int i = 1; i < 8; i++) tick();
    chk("prio_last", d3, 8'h80);
    tick();
    chk("prio_cd", cd3, 1);
    tick();
    chk("prio_idle", busy3, 0);

    // Async reset in the middle of a sweep at counter=3.
    clr3 = 1'b1;
    tick();
    clr3 = 1'b0;
    tick(); tick(); tick();
    chk("ar_pre_d", d3, 8'h08);
    #2 reset = 1'b1;
    #1;
    chk("ar_d", d3, 0);
    chk("ar_busy", busy3, 0);
    chk("ar_cd", cd3, 0);
    tick();
    chk("ar_hold_cd", cd3, 0);
    reset = 1'b0;
    en3 = 1'b1; sel3 = 3'd2;
    tick();
    en3 = 1'b0;
    chk("ar_after_d", d3, 8'h04);
    chk("ar_after_cd", cd3, 0);
    chk("ar_after_busy", busy3, 0);

    // Full sweep on the wide instance, including slot 31.
    clr5 = 1'b1;
    tick();
    clr5 = 1'b0;
    chk("sw5_0", d5, exp5(0));
    for (int i = 1; i < 32; i++) begin
      tick();
      chk($sformatf("sw5_%0d", i), d5, exp5(i));
    end
    tick();
    chk("sw5_done_d", d5, 0);
    chk("sw5_done_cd", cd5, 1);
    tick();
    chk("sw5_idle_busy", busy5, 0);
    chk("sw5_idle_cd", cd5, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_decoder.md
REG_DECODER -- requirements
Module: reg_decoder

Interface
REQ-001 SHALL have parameter SEL_W, default 5: select width; OUT_W = 2**SEL_W outputs (derived, not overridable).
REQ-002 SHALL have parameter ZERO_IDX, default 31: index of the hardwired-zero output, used only under REQ-024.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port sel, input, SEL_W: index to decode.
REQ-006 SHALL have port enable, input, 1: request a one-hot decode of sel.
REQ-007 SHALL have port clear_req, input, 1: request a sweep across all outputs.
REQ-008 SHALL have port d, output, OUT_W: registered one-hot (or all-zero) decode.
REQ-009 SHALL have port busy, output, 1: high while the sweep FSM is not IDLE.
REQ-010 SHALL have port clear_done, output, 1: one-cycle pulse at sweep completion.

Function
REQ-011 SHALL implement FSM states IDLE, SWEEP, DONE, plus an SEL_W-bit sweep counter.
REQ-012 In IDLE with clear_req=0, d SHALL register onehot(sel) if enable=1, else all zeros; latency is one clock.
REQ-013 d SHALL never have more than one bit set.
REQ-014 In IDLE with clear_req=1, the FSM SHALL enter SWEEP. The counter SHALL load 0 and d SHALL register onehot(0) on the same edge. clear_req wins over enable, and that cycle's decode is dropped.
REQ-015 In SWEEP, each edge SHALL increment the counter and register d = onehot(counter+1). Output index OUT_W-1 is reached exactly OUT_W-1 edges after entry.
REQ-016 The edge after d = onehot(OUT_W-1) SHALL move SWEEP to DONE, clear d to zero and set clear_done=1.
REQ-017 DONE SHALL last exactly one cycle, then return to IDLE with clear_done=0.
REQ-018 busy SHALL be 1 in SWEEP and DONE and 0 in IDLE; a full sweep holds busy for OUT_W+1 cycles.
REQ-019 enable and clear_req SHALL be ignored while busy=1; no queuing occurs.
REQ-020 The counter SHALL not wrap inside SWEEP; at the terminal count it SHALL return to 0 on the SWEEP-to-DONE transition.

Reset
REQ-021 Asserting reset SHALL immediately set d=0, busy=0, clear_done=0, state=IDLE and counter=0, without waiting for clk.
REQ-022 Reset during SWEEP or DONE SHALL abort the sweep, and no clear_done pulse SHALL be produced for it.
REQ-023 On the first rising edge after reset deasserts, the block SHALL behave as IDLE per REQ-012/REQ-014.

Configuration
REQ-024 With macro REG_DECODER_ZERO_MASK_EN defined, bit ZERO_IDX of d SHALL be forced to 0 in every mode. A decode or sweep slot for ZERO_IDX yields all-zero d, and sweep timing is unchanged.
REQ-025 Without REG_DECODER_ZERO_MASK_EN, all OUT_W bits SHALL be decodable, and ZERO_IDX SHALL have no effect.

Verification
REQ-026 Decode: SEL_W=5, enable=1, sel stepped 0..31 one per clock -> d equals 1<<sel one clock later (bit 31 zero if the macro is defined); enable=0 -> d=0 next clock.
REQ-027 Sweep: SEL_W=3, pulse clear_req for one cycle -> d = 0x01,0x02,...,0x80 on 8 consecutive edges, then d=0 with clear_done=1 for 1 cycle; busy high for 9 cycles.
REQ-028 Priority/ignore: enable=1, sel=5, clear_req=1 in the same IDLE cycle -> d=0x01 (sweep start), not 0x20; clear_req and enable pulses mid-sweep -> sweep sequence unchanged, no restart.
REQ-029 Async reset: assert reset mid-clock during SWEEP at counter=3 -> d=0 and busy=0 before the next edge, no clear_done; after release, enable=1, sel=2 -> d=0x04.
REQ-030 Mask: SEL_W=5, ZERO_IDX=31, macro defined -> sel=31 with enable=1 gives d=0, and sweep slot 31 gives d=0 with clear_done still on the following edge; macro undefined -> d=0x80000000.
